// File: rtl/noc_credit_arb_bridge.sv
// Multi-channel credit-to-val/rdy bridge: per-channel credit FIFOs arbitrated
// round-robin at packet granularity onto a single val/rdy output.

module ncab_chan_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic              yummy_o,
  output logic              overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]       wptr_q, rptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              full, push;
  logic              yum_q, ovf_q;

  // Extra MSB on the pointers separates full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push    = valid_i && (!full || pop_i);
  assign head_o  = mem_q[rptr_q[AW-1:0]];
  assign yummy_o    = yum_q;
  assign overflow_o = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      yum_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (push)  wptr_q <= wptr_q + PTR_ONE;
      if (pop_i) rptr_q <= rptr_q + PTR_ONE;
      yum_q <= pop_i;
      ovf_q <= ovf_q | (valid_i && !push);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end
endmodule

module noc_credit_arb_bridge #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 4,
  parameter int LEN_LSB = 22,
  parameter int LEN_W   = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_yummy,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_chan,
  output logic [NUM_CH-1:0]        overflow_o
);
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_BODY} state_e;

  state_e                          state_q, state_d;
  logic [CH_W-1:0]                 g_q, g_d, rr_q, rr_d, pick, next_rr;
  logic [LEN_W-1:0]                rem_q, rem_d, len;
  logic [NUM_CH-1:0][DATA_W-1:0]   head;
  logic [NUM_CH-1:0]               empty, pop;
  logic [DATA_W-1:0]               cur_head;
  logic                            hs, found_hi, found_lo;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ncab_chan_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_i    (in_valid[i]),
      .data_i     (in_data[i*DATA_W +: DATA_W]),
      .pop_i      (pop[i]),
      .head_o     (head[i]),
      .empty_o    (empty[i]),
      .yummy_o    (in_yummy[i]),
      .overflow_o (overflow_o[i])
    );
    assign pop[i] = hs && (g_q == CH_W'(i));
  end

  assign cur_head  = head[g_q];
  assign len       = cur_head[LEN_LSB +: LEN_W];
  assign out_valid = (state_q != ST_IDLE) && !empty[g_q];
  assign out_data  = (state_q != ST_IDLE) ? cur_head : '0;
  assign out_chan  = (state_q != ST_IDLE) ? g_q : '0;
  assign hs        = out_valid && out_ready;
  assign next_rr   = (g_q == CH_W'(NUM_CH-1)) ? '0 : g_q + CH_W'(1);

  // Round-robin: first non-empty channel at or above rr, else first from 0.
  always_comb begin
    pick     = rr_q;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!found_hi && !empty[j] && (CH_W'(j) >= rr_q)) begin
        found_hi = 1'b1;
        pick     = CH_W'(j);
      end
    end
    if (!found_hi) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (!found_lo && !empty[j]) begin
          found_lo = 1'b1;
          pick     = CH_W'(j);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (found_hi || found_lo) begin
          g_d     = pick;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (hs) begin
          if (len == '0) begin
            state_d = ST_IDLE;
            rr_d    = next_rr;
          end else begin
            rem_d   = len;
            state_d = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (hs) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_IDLE;
            rr_d    = next_rr;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      rr_q    <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      rem_q   <= rem_d;
    end
  end
endmodule

// File: tb/tb_noc_credit_arb_bridge.sv
// Bench for noc_credit_arb_bridge: queue-based packet model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.

module tb_noc_credit_arb_bridge;
  localparam int NCH = 4, DW = 64, DEPTH = 4, LEN_LSB = 22, LEN_W = 8, CH_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_yummy;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_ready;
  logic [CH_W-1:0]   out_chan;
  logic [NCH-1:0]    overflow_o;

  noc_credit_arb_bridge #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEPTH),
                          .LEN_LSB(LEN_LSB), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_yummy(in_yummy), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .out_chan(out_chan), .overflow_o(overflow_o));

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: per-channel queues plus the packet currently owning the output.
  logic [DW-1:0] mq [NCH][$];
  bit            m_own, m_hdr;
  int            m_ch, m_left, m_rr;
  bit [NCH-1:0]  m_yum, m_ovf;

  always @(posedge clk or negedge rst_n) begin
    bit [NCH-1:0] popd;
    logic [DW-1:0] f;
    int c;
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) mq[i].delete();
      m_own = 0; m_hdr = 0; m_ch = 0; m_left = 0; m_rr = 0; m_yum = '0; m_ovf = '0;
    end else begin
      cyc++;
      popd = '0;
      if (m_own) begin
        if (mq[m_ch].size() > 0 && out_ready) begin
          f = mq[m_ch].pop_front();
          popd[m_ch] = 1'b1;
          if (m_hdr) begin m_left = int'(f[LEN_LSB +: LEN_W]); m_hdr = 0; end
          else m_left--;
          if (m_left == 0) begin m_own = 0; m_rr = (m_ch + 1) % NCH; end
        end
      end else begin
        for (int k = 0; k < NCH; k++) begin
          c = (m_rr + k) % NCH;
          if (!m_own && mq[c].size() > 0) begin m_own = 1; m_hdr = 1; m_ch = c; end
        end
      end
      for (int i = 0; i < NCH; i++)
        if (in_valid[i]) begin
          if (mq[i].size() < DEPTH) mq[i].push_back(in_data[i*DW +: DW]);
          else m_ovf[i] = 1'b1;
        end
      m_yum = popd;
    end
  end

  // Handshake log of what actually left the DUT, for literal ordering checks.
  int            lg_ch[$];
  logic [DW-1:0] lg_d[$];
  int            lg_cyc[$];

  always @(negedge clk) begin
    bit ev;
    ev = m_own && (mq[m_ch].size() > 0);
    chk("out_valid", out_valid, ev);
    if (ev) begin
      chk("out_data", out_data, mq[m_ch][0]);
      chk("out_chan", out_chan, m_ch);
    end
    chk("in_yummy", in_yummy, m_yum);
    chk("overflow", overflow_o, m_ovf);
    if (rst_n && out_valid && out_ready) begin
      lg_ch.push_back(int'(out_chan)); lg_d.push_back(out_data); lg_cyc.push_back(cyc);
    end
  end

  // Credit-respecting senders.
  int credits[NCH];
  int snd_rem[NCH];
  bit stop_new = 0;
  int len_mode = 0;

  always @(negedge clk)
    if (rst_n) for (int i = 0; i < NCH; i++) credits[i] += int'(in_yummy[i]);

  function automatic logic [63:0] hdr(int len, int tag);
    logic [63:0] f;
    f = {tag[31:0], 32'h0};
    f[LEN_LSB +: LEN_W] = len[LEN_W-1:0];
    return f;
  endfunction

  function automatic logic [63:0] body(int tag, int idx);
    return {tag[31:0], 16'hB0D0, idx[15:0]};
  endfunction

  task automatic push(int ch, logic [63:0] d);
    in_valid[ch] = 1'b1;
    in_data[ch*DW +: DW] = d;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    in_valid = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
    lg_ch.delete(); lg_d.delete(); lg_cyc.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NCH; i++) begin credits[i] = DEPTH; snd_rem[i] = 0; end
    stop_new = 0;
  endtask

  task automatic sender_step(int pct);
    logic [63:0] f;
    int l;
    for (int i = 0; i < NCH; i++) begin
      if (credits[i] > 0 && $urandom_range(99) < pct && !(stop_new && snd_rem[i] == 0)) begin
        f = {$urandom, $urandom};
        if (snd_rem[i] == 0) begin
          if (len_mode == 0) l = 0;
          else if ($urandom_range(63) == 0) l = 255;
          else l = $urandom_range(4);
          f[LEN_LSB +: LEN_W] = LEN_W'(l);
          snd_rem[i] = l;
        end else snd_rem[i]--;
        push(i, f);
        credits[i]--;
      end
    end
  endtask

  function automatic bit model_drained();
    bit d;
    d = !m_own;
    for (int i = 0; i < NCH; i++) if (mq[i].size() != 0 || snd_rem[i] != 0) d = 0;
    return d;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ny, n, stall;
    in_valid = '0; in_data = '0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < NCH; i++) begin credits[i] = DEPTH; snd_rem[i] = 0; end

    // 1: async reset mid-cycle, then 2-cycle latency and yummy after handshake
    push(0, hdr(0, 1)); tick(); tick(); tick();
    chk("t1_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_valid", out_valid, 0);
    chk("t1_rst_data", out_data, 0);
    chk("t1_rst_chan", out_chan, 0);
    chk("t1_rst_yummy", in_yummy, 0);
    chk("t1_rst_ovf", overflow_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    push(0, hdr(0, 2)); tick();
    chk("t1_c1_valid", out_valid, 0);
    tick();
    chk("t1_c2_valid", out_valid, 1);
    chk("t1_c2_chan", out_chan, 0);
    chk("t1_c2_data", out_data, hdr(0, 2));
    tick();
    chk("t1_yummy", in_yummy[0], 1);
    chk("t1_after_valid", out_valid, 0);

    // 2: packet atomicity
    do_reset(); out_ready = 1'b1;
    push(0, hdr(3, 20)); push(1, hdr(1, 21)); tick();
    push(0, body(20, 1)); push(1, body(21, 1)); tick();
    push(0, body(20, 2)); tick();
    push(0, body(20, 3)); tick();
    repeat (12) tick();
    chk("t2_count", lg_ch.size(), 6);
    if (lg_ch.size() == 6) begin
      chk("t2_order", {lg_ch[0][3:0], lg_ch[1][3:0], lg_ch[2][3:0], lg_ch[3][3:0],
                       lg_ch[4][3:0], lg_ch[5][3:0]}, 24'h000011);
      chk("t2_d0", lg_d[0], hdr(3, 20));
      chk("t2_d3", lg_d[3], body(20, 3));
      chk("t2_d4", lg_d[4], hdr(1, 21));
      chk("t2_d5", lg_d[5], body(21, 1));
      chk("t2_gap_body", lg_cyc[3] - lg_cyc[2], 1);
      chk("t2_gap_idle", lg_cyc[4] - lg_cyc[3], 2);
    end

    // 3: round-robin fairness with continuous len=0 traffic
    do_reset(); out_ready = 1'b1; len_mode = 0;
    repeat (40) begin tick(); sender_step(100); end
    tick();
    chk("t3_count_ge12", lg_ch.size() >= 12, 1);
    if (lg_ch.size() >= 12)
      for (int i = 0; i < 12; i++) chk("t3_rr_order", lg_ch[i], i % 4);

    // 4: backpressure, no credits returned, overflow on 5th push
    do_reset(); out_ready = 1'b0; ny = 0;
    push(1, hdr(3, 40)); tick(); ny += int'(in_yummy[1]);
    for (int b = 1; b <= 3; b++) begin push(1, body(40, b)); tick(); ny += int'(in_yummy[1]); end
    repeat (3) begin tick(); ny += int'(in_yummy[1]); end
    chk("t4_no_yummy", ny, 0);
    chk("t4_ovf_before", overflow_o[1], 0);
    push(1, hdr(0, 32'h99)); tick();
    chk("t4_ovf_after", overflow_o[1], 1);
    out_ready = 1'b1; ny = 0;
    repeat (14) begin tick(); ny += int'(in_yummy[1]); end
    chk("t4_yummies", ny, 4);
    chk("t4_out_count", lg_d.size(), 4);
    if (lg_d.size() == 4) chk("t4_last", lg_d[3], body(40, 3));

    // 5: full FIFO with simultaneous push and pop
    do_reset(); out_ready = 1'b0;
    push(0, hdr(4, 50)); tick();
    for (int b = 1; b <= 3; b++) begin push(0, body(50, b)); tick(); end
    tick(); tick();
    out_ready = 1'b1; push(0, body(50, 4)); tick();
    out_ready = 1'b0;
    chk("t5_ovf", overflow_o[0], 0);
    chk("t5_head", out_data, body(50, 1));
    out_ready = 1'b1;
    repeat (12) tick();
    chk("t5_count", lg_d.size(), 5);
    if (lg_d.size() == 5) chk("t5_last", lg_d[4], body(50, 4));

    // 6: reset in the middle of a body
    do_reset(); out_ready = 1'b1;
    push(0, hdr(5, 60)); tick();
    for (int b = 1; b <= 3; b++) begin push(0, body(60, b)); tick(); end
    n = 0;
    while (lg_d.size() < 3 && n < 20) begin tick(); n++; end
    chk("t6_reached_body", lg_d.size(), 3);
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_valid", out_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) tick();
    chk("t6_no_stale", lg_d.size(), 3);
    chk("t6_idle_valid", out_valid, 0);
    push(0, hdr(0, 61)); repeat (5) tick();
    chk("t6_new_count", lg_d.size(), 4);
    if (lg_d.size() == 4) chk("t6_new_data", lg_d[3], hdr(0, 61));

    // Randomized traffic with random backpressure
    do_reset(); len_mode = 1; stall = 0;
    repeat (3000) begin
      tick();
      if (stall == 0 && $urandom_range(199) == 0) stall = $urandom_range(40);
      if (stall > 0) begin out_ready = 1'b0; stall--; end
      else out_ready = ($urandom_range(3) != 0);
      sender_step(75);
    end
    stop_new = 1; n = 0;
    while (!model_drained() && n < 3000) begin
      tick(); out_ready = 1'b1; sender_step(100); n++;
    end
    chk("rand_drained", n < 3000, 1);
    repeat (3) tick();
    chk("rand_no_ovf", overflow_o, 0);
    chk("rand_idle", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
